// File: rtl/dilithium_core_arbiter_if.sv
// ---------------------------------------------------------------------------
// dilithium_core_arbiter_if
// Bundles every handshake/bus signal between the two requesters, the shared
// Dilithium core and the arbiter.
//   slave  : arbiter view (requester-side and core-side inputs in, routed
//            strobes/data, grant, done, err, core_start/abort and busy out)
//   master : environment view (requesters plus core, the reverse direction)
// Requester-indexed vectors use bit i / slice i for requester i.
// ---------------------------------------------------------------------------
interface dilithium_core_arbiter_if #(
  parameter int DATA_W = 64
);
  // requester command side
  logic [1:0]          req;
  logic [3:0]          req_mode;
  logic [5:0]          req_sec_lvl;
  logic [1:0]          grant;
  logic [1:0]          done;
  logic [1:0]          err;
  // requester streams
  logic [1:0]          s_valid;
  logic [1:0]          s_ready;
  logic [2*DATA_W-1:0] s_data;
  logic [1:0]          m_valid;
  logic [1:0]          m_ready;
  logic [DATA_W-1:0]   m_data;
  logic [1:0]          m_last;
  // core side
  logic                core_start;
  logic [1:0]          core_mode;
  logic [2:0]          core_sec_lvl;
  logic                core_valid_i;
  logic                core_ready_i;
  logic [DATA_W-1:0]   core_data_i;
  logic                core_valid_o;
  logic                core_ready_o;
  logic [DATA_W-1:0]   core_data_o;
  logic                core_last;
  logic                core_abort;
  logic                busy;

  modport slave (
    input  req, req_mode, req_sec_lvl, s_valid, s_data, m_ready,
           core_ready_i, core_valid_o, core_data_o, core_last,
    output grant, done, err, s_ready, m_valid, m_data, m_last,
           core_start, core_mode, core_sec_lvl, core_valid_i, core_data_i,
           core_ready_o, core_abort, busy
  );

  modport master (
    output req, req_mode, req_sec_lvl, s_valid, s_data, m_ready,
           core_ready_i, core_valid_o, core_data_o, core_last,
    input  grant, done, err, s_ready, m_valid, m_data, m_last,
           core_start, core_mode, core_sec_lvl, core_valid_i, core_data_i,
           core_ready_o, core_abort, busy
  );
endinterface

// File: rtl/dilithium_core_arbiter.sv
// ---------------------------------------------------------------------------
// dilithium_core_arbiter
// Shares one Dilithium core between two requesters. Owner selection is
// round-robin on ties, the command is latched and checked, the core gets a
// one-cycle start, both streams are routed to/from the owner while running,
// and the core is released after the owner takes the last output beat.
// A watchdog aborts jobs that make no stream progress for WDOG_LIMIT cycles.
// Ports:
//   i_clk  : clock
//   i_rst  : asynchronous, active-low reset
//   arb    : dilithium_core_arbiter_if.slave (requester + core signals)
// Control outputs are flops loaded from the next state, so they line up
// exactly with the state they describe; the stream routing in RUN is
// combinational so the owner and the core see each other with no bubble.
// ---------------------------------------------------------------------------
module dilithium_core_arbiter #(
  parameter int DATA_W     = 64,
  parameter int WDOG_W     = 20,
  parameter int WDOG_LIMIT = 1000000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  dilithium_core_arbiter_if.slave  arb
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  // last idle count that is still tolerated before the abort decision
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

  function automatic logic [1:0] f_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

  function automatic logic f_cmd_legal(input logic [1:0] mode, input logic [2:0] sec);
    return (mode != 2'd3) && ((sec == 3'd2) || (sec == 3'd3) || (sec == 3'd5));
  endfunction

  state_t            r_state, w_state_nxt;
  logic              r_owner, w_owner_nxt;
  logic              r_rr_last, w_rr_last_nxt;
  logic              r_err_flag, w_err_flag_nxt;
  logic [WDOG_W-1:0] r_wdog, w_wdog_nxt;
  logic              w_latch;
  logic              w_pick;
  logic [1:0]        w_cmd_mode;
  logic [2:0]        w_cmd_sec;
  logic              w_in_hs, w_out_hs;

  logic [1:0]        r_core_mode;
  logic [2:0]        r_core_sec_lvl;
  logic [1:0]        r_grant, w_grant_nxt;
  logic [1:0]        r_done, w_done_nxt;
  logic [1:0]        r_err, w_err_nxt;
  logic              r_core_start, w_start_nxt;
  logic              r_core_abort, w_abort_nxt;
  logic              r_busy, w_busy_nxt;
  logic [1:0]        w_oh_nxt;

  logic              w_core_valid_i;
  logic [DATA_W-1:0] w_core_data_i;
  logic              w_core_ready_o;
  logic [1:0]        w_s_ready, w_m_valid, w_m_last;

  // Owner candidate in IDLE: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    w_pick = r_owner;
    case (arb.req)
      2'b01:   w_pick = 1'b0;
      2'b10:   w_pick = 1'b1;
      2'b11:   w_pick = ~r_rr_last;
      default: w_pick = r_owner;
    endcase
    w_cmd_mode = w_pick ? arb.req_mode[3:2]    : arb.req_mode[1:0];
    w_cmd_sec  = w_pick ? arb.req_sec_lvl[5:3] : arb.req_sec_lvl[2:0];
  end

  assign w_in_hs  = (r_state == ST_RUN) & arb.s_valid[r_owner] & arb.core_ready_i;
  assign w_out_hs = (r_state == ST_RUN) & arb.core_valid_o & arb.m_ready[r_owner];

  // Next-state, owner, error flag and watchdog decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_rr_last_nxt  = r_rr_last;
    w_err_flag_nxt = r_err_flag;
    w_wdog_nxt     = r_wdog;
    w_latch        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (arb.req != 2'b00) begin
          w_owner_nxt = w_pick;
          w_latch     = 1'b1;
          if (f_cmd_legal(w_cmd_mode, w_cmd_sec)) begin
            w_state_nxt    = ST_START;
            w_err_flag_nxt = 1'b0;
          end else begin
            // rejected commands skip the core entirely
            w_state_nxt    = ST_DONE;
            w_err_flag_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        w_state_nxt = ST_RUN;
        w_wdog_nxt  = '0;
      end
      ST_RUN: begin
        if (w_out_hs && arb.core_last) begin
          w_state_nxt = ST_DONE;
          w_wdog_nxt  = '0;
        end else if (w_in_hs || w_out_hs) begin
          w_wdog_nxt  = '0;
        end else if (r_wdog == WDOG_LAST) begin
          w_state_nxt = ST_ABORT;
          w_wdog_nxt  = '0;
        end else begin
          w_wdog_nxt  = r_wdog + 1'b1;
        end
      end
      ST_ABORT: begin
        w_state_nxt    = ST_DONE;
        w_err_flag_nxt = 1'b1;
      end
      ST_DONE: begin
        w_state_nxt   = ST_IDLE;
        w_rr_last_nxt = r_owner;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control outputs derived from the state being entered.
  always_comb begin
    w_oh_nxt    = f_onehot(w_owner_nxt);
    w_grant_nxt = 2'b00;
    w_done_nxt  = 2'b00;
    w_err_nxt   = 2'b00;
    w_start_nxt = 1'b0;
    w_abort_nxt = 1'b0;
    w_busy_nxt  = 1'b1;
    case (w_state_nxt)
      ST_IDLE:  w_busy_nxt = 1'b0;
      ST_START: begin
        w_grant_nxt = w_oh_nxt;
        w_start_nxt = 1'b1;
      end
      ST_RUN:   w_grant_nxt = w_oh_nxt;
      ST_ABORT: begin
        w_grant_nxt = w_oh_nxt;
        w_abort_nxt = 1'b1;
      end
      ST_DONE: begin
        w_grant_nxt = w_oh_nxt;
        w_done_nxt  = w_oh_nxt;
        w_err_nxt   = w_err_flag_nxt ? w_oh_nxt : 2'b00;
      end
      default:  w_busy_nxt = 1'b0;
    endcase
  end

  // State, bookkeeping and registered control outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state        <= ST_IDLE;
      r_owner        <= 1'b0;
      r_rr_last      <= 1'b1;
      r_err_flag     <= 1'b0;
      r_wdog         <= '0;
      r_core_mode    <= 2'd0;
      r_core_sec_lvl <= 3'd0;
      r_grant        <= 2'b00;
      r_done         <= 2'b00;
      r_err          <= 2'b00;
      r_core_start   <= 1'b0;
      r_core_abort   <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_rr_last    <= w_rr_last_nxt;
      r_err_flag   <= w_err_flag_nxt;
      r_wdog       <= w_wdog_nxt;
      if (w_latch) begin
        r_core_mode    <= w_cmd_mode;
        r_core_sec_lvl <= w_cmd_sec;
      end
      r_grant      <= w_grant_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_core_start <= w_start_nxt;
      r_core_abort <= w_abort_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Stream routing: only the owner is connected, and only while RUN.
  always_comb begin
    w_core_valid_i = 1'b0;
    w_core_data_i  = '0;
    w_core_ready_o = 1'b0;
    w_s_ready      = 2'b00;
    w_m_valid      = 2'b00;
    w_m_last       = 2'b00;
    if (r_state == ST_RUN) begin
      w_core_valid_i       = arb.s_valid[r_owner];
      w_core_data_i        = r_owner ? arb.s_data[2*DATA_W-1:DATA_W] : arb.s_data[DATA_W-1:0];
      w_core_ready_o       = arb.m_ready[r_owner];
      w_s_ready[r_owner]   = arb.core_ready_i;
      w_m_valid[r_owner]   = arb.core_valid_o;
      w_m_last[r_owner]    = arb.core_last & arb.core_valid_o;
    end else begin
      w_core_valid_i = 1'b0;
    end
  end

  assign arb.core_valid_i = w_core_valid_i;
  assign arb.core_data_i  = w_core_data_i;
  assign arb.core_ready_o = w_core_ready_o;
  assign arb.s_ready      = w_s_ready;
  assign arb.m_valid      = w_m_valid;
  assign arb.m_last       = w_m_last;
  assign arb.m_data       = arb.core_data_o;
  assign arb.core_mode    = r_core_mode;
  assign arb.core_sec_lvl = r_core_sec_lvl;
  assign arb.grant        = r_grant;
  assign arb.done         = r_done;
  assign arb.err          = r_err;
  assign arb.core_start   = r_core_start;
  assign arb.core_abort   = r_core_abort;
  assign arb.busy         = r_busy;

endmodule
